// File: rtl/wb_dbg_master_pkg.sv
// Shared constants for the Wishbone debug master.
// Command/status codes, state encoding, byte select helper.
package wb_dbg_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] STS_ACK = 8'hA5;
    localparam logic [7:0] STS_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Byte i (1..4) of a word, MSB first.
    function automatic logic [7:0] resp_byte(
        input logic [31:0] w,
        input logic [2:0]  i
    );
        case (i)
            3'd1:    return w[31:24];
            3'd2:    return w[23:16];
            3'd3:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/wb_dbg_master_if.sv
// Byte streams plus Wishbone master bus.
// master = debug bridge side, slave = host/bus side.
interface wb_dbg_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output rx_ready, tx_data, tx_valid,
        output wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  rx_ready, tx_data, tx_valid,
        input  wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/wb_dbg_master.sv
// Byte-stream driven Wishbone debug master.
// Parses read/write commands, runs one bus cycle, streams back status.
module wb_dbg_master
    import wb_dbg_master_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    wb_dbg_master_if.master  bus,
    output logic             busy
);

    localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

    logic        rst_n;
    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [15:0] tmo_q;
    logic        we_q;
    logic        cyc_q;
    logic        err_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rdat_q;

    logic rx_fire;
    logic tx_fire;
    logic is_cmd;
    logic term;
    logic ack_ok;
    logic tmo_hit;
    logic last_byte;

    assign rx_fire   = bus.rx_valid & bus.rx_ready;
    assign tx_fire   = tx_valid_q & bus.tx_ready;
    assign is_cmd    = (bus.rx_data == CMD_WR) |
                       (bus.rx_data == CMD_RD);
    assign term      = bus.wb_ack_i | bus.wb_err_i;
    assign ack_ok    = bus.wb_ack_i & ~bus.wb_err_i;
    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign last_byte = err_q | we_q | (idx_q == 3'd4);

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_n <= 1'b0;
        else          rst_n <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (rx_fire && is_cmd) state_d = ST_ADDR;
            ST_ADDR:
                if (rx_fire && cnt_q == 2'd3)
                    state_d = we_q ? ST_WDATA : ST_BUS;
            ST_WDATA:
                if (rx_fire && cnt_q == 2'd3) state_d = ST_BUS;
            ST_BUS:
                if (term || tmo_hit) state_d = ST_RESP;
            ST_RESP:
                if (tx_fire && last_byte) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        bus.rx_ready = rst_n & ((state_q == ST_IDLE) |
                                (state_q == ST_ADDR) |
                                (state_q == ST_WDATA));
        busy         = (state_q != ST_IDLE);
        bus.wb_cyc_o = cyc_q;
        bus.wb_stb_o = cyc_q;
        bus.wb_sel_o = 4'hf;
        bus.wb_we_o  = we_q;
        bus.wb_adr_o = adr_q;
        bus.wb_dat_o = dat_q;
        bus.tx_valid = tx_valid_q;
        bus.tx_data  = tx_data_q;
    end

    // Command capture, bus cycle and response datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdat_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rx_fire && is_cmd)
                        we_q <= (bus.rx_data == CMD_WR);
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        adr_q <= {adr_q[23:0], bus.rx_data};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3 && !we_q) begin
                            cyc_q <= 1'b1;
                            tmo_q <= '0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_fire) begin
                        dat_q <= {dat_q[23:0], bus.rx_data};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cyc_q <= 1'b1;
                            tmo_q <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (term || tmo_hit) begin
                        cyc_q      <= 1'b0;
                        err_q      <= ~ack_ok;
                        rdat_q     <= bus.wb_dat_i;
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ack_ok ? STS_ACK : STS_ERR;
                    end
                end
                ST_RESP: begin
                    if (tx_fire) begin
                        if (last_byte) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= resp_byte(rdat_q,
                                                   idx_q + 3'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Randomized self-checking bench for wb_dbg_master.
// Reference: command/response rules modelled with plain queues.
module tb_wb_dbg_master;
    import wb_dbg_master_pkg::*;

    localparam int TMO    = 8;
    localparam int S_ACK  = 0;
    localparam int S_ERR  = 1;
    localparam int S_BOTH = 2;
    localparam int S_NONE = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    wb_dbg_master_if bus();

    wb_dbg_master #(.timeout_cycles(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_bytes[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        int n;
        g = $urandom_range(0, 2);
        n = 0;
        repeat (g) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_ready_wait", 32'(bus.rx_ready), 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_cmd(input logic we,
                            input logic [31:0] adr,
                            input logic [31:0] dat);
        logic [31:0] w;
        send_byte(we ? CMD_WR : CMD_RD);
        w = adr;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31:24]);
            w = w << 8;
        end
        if (we) begin
            w = dat;
            for (int i = 0; i < 4; i++) begin
                send_byte(w[31:24]);
                w = w << 8;
            end
        end
    endtask

    task automatic bus_phase(input logic we,
                             input logic [31:0] adr,
                             input logic [31:0] dat,
                             input int mode,
                             input int wait_n,
                             input logic [31:0] rdata);
        int n;
        n = 0;
        check("cyc_rise", 32'(bus.wb_cyc_o), 1);
        while (bus.wb_cyc_o && n < 100) begin
            n++;
            check("stb", 32'(bus.wb_stb_o), 1);
            check("adr", bus.wb_adr_o, adr);
            check("we", 32'(bus.wb_we_o), 32'(we));
            check("sel", 32'(bus.wb_sel_o), 32'hf);
            if (we) check("dat_o", bus.wb_dat_o, dat);
            check("rx_ready_bus", 32'(bus.rx_ready), 0);
            if (mode != S_NONE && n == wait_n + 1) begin
                bus.wb_ack_i = (mode != S_ERR);
                bus.wb_err_i = (mode != S_ACK);
                bus.wb_dat_i = rdata;
            end else begin
                bus.wb_ack_i = 1'b0;
                bus.wb_err_i = 1'b0;
                bus.wb_dat_i = $urandom;
            end
            @(negedge clk);
        end
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        check("cyc_len", n, (mode == S_NONE) ? TMO : wait_n + 1);
        check("stb_low", 32'(bus.wb_stb_o), 0);
    endtask

    task automatic resp_phase(input int pat);
        logic [7:0] got[$];
        logic       held;
        logic [7:0] hv;
        logic       r;
        int         cyc;
        held = 1'b0;
        hv   = '0;
        cyc  = 0;
        while (got.size() < exp_bytes.size() && cyc < 300) begin
            case (pat)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc % 3 == 2);
            endcase
            if (held) begin
                check("tx_hold", 32'(bus.tx_valid), 1);
                check("tx_stable", 32'(bus.tx_data), 32'(hv));
            end
            if (bus.tx_valid) begin
                if (r) got.push_back(bus.tx_data);
                held = !r;
                hv   = bus.tx_data;
            end else begin
                held = 1'b0;
            end
            bus.tx_ready = r;
            @(negedge clk);
            cyc++;
        end
        bus.tx_ready = 1'b0;
        check("tx_count", got.size(), exp_bytes.size());
        foreach (exp_bytes[i])
            if (i < got.size())
                check("tx_byte", 32'(got[i]), 32'(exp_bytes[i]));
        check("tx_idle", 32'(bus.tx_valid), 0);
        check("busy_end", 32'(busy), 0);
        check("rx_ready_end", 32'(bus.rx_ready), 1);
    endtask

    task automatic run_txn(input logic we,
                           input logic [31:0] adr,
                           input logic [31:0] dat,
                           input int mode,
                           input int wait_n,
                           input logic [31:0] rdata,
                           input int pat);
        logic [31:0] w;
        send_cmd(we, adr, dat);
        bus_phase(we, adr, dat, mode, wait_n, rdata);
        exp_bytes.delete();
        exp_bytes.push_back(mode == S_ACK ? 8'hA5 : 8'hEE);
        if (mode == S_ACK && !we) begin
            w = rdata;
            for (int i = 0; i < 4; i++) begin
                exp_bytes.push_back(w[31:24]);
                w = w << 8;
            end
        end
        resp_phase(pat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.wb_dat_i = '0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(bus.wb_cyc_o), 0);
        check("rst_stb", 32'(bus.wb_stb_o), 0);
        check("rst_we", 32'(bus.wb_we_o), 0);
        check("rst_adr", bus.wb_adr_o, 0);
        check("rst_dat", bus.wb_dat_o, 0);
        check("rst_sel", 32'(bus.wb_sel_o), 32'hf);
        check("rst_txv", 32'(bus.tx_valid), 0);
        check("rst_txd", 32'(bus.tx_data), 0);
        check("rst_rxr", 32'(bus.rx_ready), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        #1 check("rxr_sync", 32'(bus.rx_ready), 0);
        @(negedge clk);
        check("rxr_after_rst", 32'(bus.rx_ready), 1);

        run_txn(1'b1, 32'h0000_7002, 32'hDEAD_BEEF,
                S_ACK, 2, 32'h0, 0);
        run_txn(1'b0, 32'h4000_0010, 32'h0,
                S_ACK, 1, 32'h1234_5678, 0);
        run_txn(1'b0, 32'h4000_0020, 32'h0,
                S_NONE, 0, 32'h0, 0);
        run_txn(1'b0, 32'h4000_0030, 32'h0,
                S_BOTH, 0, 32'hCAFE_F00D, 0);
        run_txn(1'b1, 32'h4000_0034, 32'h1111_2222,
                S_ERR, 3, 32'h0, 1);

        send_byte(8'h55);
        @(negedge clk);
        check("unk_busy", 32'(busy), 0);
        check("unk_txv", 32'(bus.tx_valid), 0);
        run_txn(1'b1, 32'h0000_0100, 32'h0BAD_F00D,
                S_ACK, 0, 32'h0, 0);

        run_txn(1'b0, 32'h8000_0004, 32'h0,
                S_ACK, 3, 32'h89AB_CDEF, 2);
        run_txn(1'b0, 32'h8000_0008, 32'h0,
                S_ACK, TMO - 1, 32'h0F1E_2D3C, 1);

        send_cmd(1'b0, 32'h1234_0000, 32'h0);
        check("mid_cyc", 32'(bus.wb_cyc_o), 1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(bus.wb_cyc_o), 0);
        check("mid_rst_stb", 32'(bus.wb_stb_o), 0);
        check("mid_rst_txv", 32'(bus.tx_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_adr", bus.wb_adr_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rxr", 32'(bus.rx_ready), 1);
        run_txn(1'b1, 32'h0000_0200, 32'h5A5A_A5A5,
                S_ACK, 1, 32'h0, 0);

        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    (r < 6) ? S_ACK : (r < 8) ? S_ERR :
                    (r < 9) ? S_BOTH : S_NONE,
                    $urandom_range(0, TMO - 1), $urandom,
                    $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dbg_master.md
WB_DBG_MASTER -- requirements
Module: wb_dbg_master

Interface
REQ-001 SHALL have parameter timeout_cycles, default 255, meaning bus cycles allowed per transfer before abort (legal 1..65535).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, one clock domain, asynchronous, active-low reset.
REQ-004 SHALL have ports rx_data input 8, rx_valid input 1, rx_ready output 1: command byte stream; a byte transfers on rx_valid & rx_ready.
REQ-005 SHALL have ports tx_data output 8, tx_valid output 1, tx_ready input 1: response byte stream; a byte transfers on tx_valid & tx_ready.
REQ-006 SHALL have Wishbone master ports wb_adr_o 32, wb_dat_o 32, wb_dat_i 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_ack_i 1, wb_err_i 1 (classic single cycle).
REQ-007 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-008 SHALL implement states IDLE, ADDR, WDATA, BUS, RESP.
REQ-009 IDLE: accepted byte 0x01 -> write command, 0x02 -> read command, both go to ADDR; any other byte discarded, stay IDLE, no response.
REQ-010 ADDR: accept exactly 4 bytes, MSB first, into wb_adr_o; after 4th byte go to WDATA (write) or BUS (read).
REQ-011 WDATA: accept exactly 4 bytes, MSB first, into wb_dat_o; after 4th go to BUS.
REQ-012 rx_ready SHALL be 1 in IDLE/ADDR/WDATA, 0 in BUS/RESP.
REQ-013 wb_cyc_o and wb_stb_o SHALL rise together in the cycle after the final command byte transfers, and stay high until termination.
REQ-014 wb_sel_o SHALL be 4'hf; wb_we_o 1 for write, 0 for read, stable throughout the cycle.
REQ-015 Termination: at the edge sampling wb_ack_i or wb_err_i high, cyc/stb go low the next cycle; read data captured from wb_dat_i at that same edge.
REQ-016 wb_err_i and wb_ack_i both high in one cycle SHALL be treated as error.
REQ-017 A 16-bit counter SHALL count cycles with cyc high; when it reaches timeout_cycles with no ack/err, cyc/stb drop and result is error; ack/err at the final counted cycle wins over timeout.
REQ-018 RESP: first byte is status 0xA5 (ack) or 0xEE (err/timeout); a successful read then sends 4 data bytes MSB first; write or error sends status only.
REQ-019 tx_valid SHALL hold with tx_data stable until tx_ready; no byte dropped or repeated under backpressure.
REQ-020 After last response byte transfers, return to IDLE next cycle; no inter-byte timeout on rx.
REQ-021 wb_adr_o/wb_dat_o SHALL be full 32-bit, no alignment check; host supplies word-aligned addresses.

Reset
REQ-022 On reset_n low (async, any state, including mid-bus-cycle): state IDLE, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=4'hf, tx_valid=0, tx_data=0, rx_ready=0, busy=0, counters 0.
REQ-023 rx_ready SHALL become 1 in the first cycle after reset_n deasserts.
REQ-024 Reset release SHALL be synchronised inside the block (deassertion on clk edge).

Structure
REQ-025 Command codes (0x01, 0x02), status codes (0xA5, 0xEE) and state encodings SHALL live in a shared include/package used by firmware headers and bench.
REQ-026 Single module; no sub-module required (UART byte framing stays in the existing UART core, connected at system level).

Verification
REQ-027 Write: bytes 01 00 00 70 02 DE AD BE EF, slave acks after 2 wait cycles -> one cycle adr=0x00007002, dat=0xDEADBEEF, we=1, sel=f; response A5.
REQ-028 Read: bytes 02 40 00 00 10, slave returns 0x12345678 -> we=0, response A5 12 34 56 78.
REQ-029 Timeout: timeout_cycles=8, read to unresponsive slave -> cyc high exactly 8 cycles, response EE, then IDLE.
REQ-030 Error/priority: ack and err asserted together -> response EE; unknown byte 0x55 then valid write -> 0x55 ignored, write completes with A5.
REQ-031 Backpressure: read with tx_ready toggling 1-of-3 cycles -> exactly 5 bytes A5 + data, each held stable until accepted.
REQ-032 Reset mid-operation: reset_n low during BUS with cyc high -> cyc/stb/tx_valid 0 immediately, next command after release executes normally.
